// File: rtl/sinc_comp_fir_pkg.sv
// Shared constants, coefficient set and FSM state type for the sinc3 compensation FIR.
package adcfilter_pkg;

  localparam int unsigned DwDef    = 16;
  localparam int unsigned AccwDef  = 24;
  localparam int unsigned ShiftDef = 6;
  localparam int unsigned NumTaps  = 7;
  localparam int unsigned CoefW    = 8;
  localparam int unsigned TapIdxW  = 3;

  typedef logic signed [CoefW-1:0] coef_t;

  // Symmetric droop-compensation kernel, DC gain 64.
  localparam coef_t Coef0 = 8'sd1;
  localparam coef_t Coef1 = -8'sd4;
  localparam coef_t Coef2 = -8'sd12;
  localparam coef_t Coef3 = 8'sd94;
  localparam coef_t Coef4 = -8'sd12;
  localparam coef_t Coef5 = -8'sd4;
  localparam coef_t Coef6 = 8'sd1;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StSat
  } state_e;

endpackage

// File: rtl/sinc_comp_fir_if.sv
// Word-in / sample-out bus between the sinc3 front end and the compensation FIR.
interface sinc_comp_fir_if #(
  parameter int unsigned DW = 16
);

  logic                 en;
  logic                 dec2;
  logic                 word_clk;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 overrun;

  modport master (
    output en, dec2, word_clk, din,
    input  dout, dout_valid, overrun
  );

  modport slave (
    input  en, dec2, word_clk, din,
    output dout, dout_valid, overrun
  );

endinterface

// File: rtl/sinc_comp_fir_coef_rom.sv
// Combinational coefficient lookup by tap index.
module comp_coef_rom
  import adcfilter_pkg::*;
(
  input  logic [TapIdxW-1:0] idx_i,
  output coef_t              coef_o
);

  always_comb begin
    coef_o = '0;
    case (idx_i)
      3'd0:    coef_o = Coef0;
      3'd1:    coef_o = Coef1;
      3'd2:    coef_o = Coef2;
      3'd3:    coef_o = Coef3;
      3'd4:    coef_o = Coef4;
      3'd5:    coef_o = Coef5;
      3'd6:    coef_o = Coef6;
      default: coef_o = '0;
    endcase
  end

endmodule

// File: rtl/sinc_comp_fir.sv
// 7-tap sinc3 droop-compensation FIR: one serial MAC per output, optional decimate-by-2.
module sinc_comp_fir
  import adcfilter_pkg::*;
#(
  parameter int unsigned DW    = DwDef,
  parameter int unsigned ACCW  = AccwDef,
  parameter int unsigned SHIFT = ShiftDef
) (
  input logic            mclk1,
  input logic            reset_n,
  sinc_comp_fir_if.slave bus
);

  localparam logic signed [ACCW-1:0] SatMax = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SatMin = ~SatMax;

  state_e                     state_q, state_d;
  logic                       wc_q;
  logic signed [DW-1:0]       taps_q [NumTaps];
  logic signed [DW-1:0]       taps_d [NumTaps];
  logic signed [ACCW-1:0]     acc_q, acc_d;
  logic [TapIdxW-1:0]         k_q, k_d;
  logic                       phase_q, phase_d;
  logic signed [DW-1:0]       dout_q, dout_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  logic                       word_evt;
  logic                       accept;
  logic                       start_mac;
  coef_t                      coef;
  logic signed [DW-1:0]       tap_sel;
  logic signed [DW+CoefW-1:0] prod;
  logic signed [ACCW-1:0]     acc_shr;

  comp_coef_rom u_coef_rom (
    .idx_i  (k_q),
    .coef_o (coef)
  );

  assign word_evt  = bus.word_clk & ~wc_q;
  assign accept    = word_evt & bus.en & (state_q == StIdle);
  // With dec2 low the phase is treated as zero even before the register clears.
  assign start_mac = accept & ~(bus.dec2 & phase_q);
  assign tap_sel   = taps_q[k_q];
  assign prod      = tap_sel * coef;
  assign acc_shr   = acc_q >>> SHIFT;

  always_comb begin
    state_d   = state_q;
    taps_d    = taps_q;
    acc_d     = acc_q;
    k_d       = k_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (word_evt & bus.en & (state_q != StIdle));
    phase_d   = 1'b0;
    if (bus.dec2) begin
      phase_d = accept ? ~phase_q : phase_q;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          taps_d[0] = bus.din;
          for (int i = 1; i < NumTaps; i++) begin
            taps_d[i] = taps_q[i-1];
          end
          if (start_mac) begin
            acc_d   = '0;
            k_d     = '0;
            state_d = StMac;
          end
        end
      end
      StMac: begin
        acc_d = acc_q + ACCW'(prod);
        if (k_q == TapIdxW'(NumTaps - 1)) begin
          state_d = StSat;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StSat: begin
        if (acc_shr > SatMax) begin
          dout_d = SatMax[DW-1:0];
        end else if (acc_shr < SatMin) begin
          dout_d = SatMin[DW-1:0];
        end else begin
          dout_d = acc_shr[DW-1:0];
        end
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk1) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      wc_q      <= 1'b0;
      acc_q     <= '0;
      k_q       <= '0;
      phase_q   <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NumTaps; i++) begin
        taps_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wc_q      <= bus.word_clk;
      acc_q     <= acc_d;
      k_q       <= k_d;
      phase_q   <= phase_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      taps_q    <= taps_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sinc_comp_fir.sv
// Directed bench for sinc_comp_fir: vector table plus hand-built overrun/reset/decimation runs.
module tb_sinc_comp_fir;

  logic mclk1   = 1'b0;
  logic reset_n = 1'b0;

  sinc_comp_fir_if #(.DW(16)) bus ();

  sinc_comp_fir #(
    .DW    (16),
    .ACCW  (24),
    .SHIFT (6)
  ) dut (
    .mclk1   (mclk1),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 mclk1 = ~mclk1;

  typedef struct {
    logic signed [15:0] din;
    bit                 chk;
    int                 exp;
  } vec_t;

  vec_t               vecs[$];
  int                 n_tests  = 0;
  int                 n_fail   = 0;
  int                 n_pulses = 0;
  int                 got[$];
  logic signed [15:0] ov_vals[4];
  logic signed [15:0] d2_vals[8];
  bit                 d2_exp[8];
  int                 d2_val[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge mclk1);
    reset_n = 1'b0;
    repeat (2) @(negedge mclk1);
    reset_n = 1'b1;
  endtask

  // One word strobe; waits for the resulting output pulse (or its absence).
  task automatic send_word(input logic signed [15:0] v, input bit expect_out, input bit chk,
                           input int exp, input string name);
    int lat;
    int limit;
    bit seen;
    @(negedge mclk1);
    bus.din      = v;
    bus.word_clk = 1'b1;
    @(negedge mclk1);
    bus.word_clk = 1'b0;
    seen  = 1'b0;
    lat   = 0;
    limit = expect_out ? 20 : 12;
    for (int j = 1; j <= limit && !seen; j++) begin
      @(negedge mclk1);
      if (bus.dout_valid) begin
        seen = 1'b1;
        lat  = j;
      end
    end
    if (seen) n_pulses++;
    check({name, "_valid"}, longint'(seen), longint'(expect_out));
    if (seen && expect_out) begin
      check({name, "_latency"}, lat, 8);
      if (chk) check({name, "_dout"}, longint'(bus.dout), exp);
      @(negedge mclk1);
      check({name, "_pulse_width"}, longint'(bus.dout_valid), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    bus.en       = 1'b1;
    bus.dec2     = 1'b0;
    bus.word_clk = 1'b0;
    bus.din      = '0;
    repeat (3) @(negedge mclk1);
    reset_n = 1'b1;

    check("rst_dout", longint'(bus.dout), 0);
    check("rst_valid", longint'(bus.dout_valid), 0);
    check("rst_overrun", longint'(bus.overrun), 0);

    // Impulse of 100 through a clean delay line.
    vecs.push_back('{din: 16'sd100, chk: 1'b1, exp: 1});
    vecs.push_back('{din: 16'sd0, chk: 1'b1, exp: -7});
    vecs.push_back('{din: 16'sd0, chk: 1'b1, exp: -19});
    vecs.push_back('{din: 16'sd0, chk: 1'b1, exp: 146});
    vecs.push_back('{din: 16'sd0, chk: 1'b1, exp: -19});
    vecs.push_back('{din: 16'sd0, chk: 1'b1, exp: -7});
    vecs.push_back('{din: 16'sd0, chk: 1'b1, exp: 1});
    vecs.push_back('{din: 16'sd0, chk: 1'b1, exp: 0});
    // DC step of 1000: partial sums floor(1000*sum(c[0..k])/64), then settled.
    vecs.push_back('{din: 16'sd1000, chk: 1'b1, exp: 15});
    vecs.push_back('{din: 16'sd1000, chk: 1'b1, exp: -47});
    vecs.push_back('{din: 16'sd1000, chk: 1'b1, exp: -235});
    vecs.push_back('{din: 16'sd1000, chk: 1'b1, exp: 1234});
    vecs.push_back('{din: 16'sd1000, chk: 1'b1, exp: 1046});
    vecs.push_back('{din: 16'sd1000, chk: 1'b1, exp: 984});
    for (int i = 0; i < 4; i++) vecs.push_back('{din: 16'sd1000, chk: 1'b1, exp: 1000});
    // Worst-case pattern: unsaturated result 65534 clips to full scale.
    vecs.push_back('{din: 16'sd32767, chk: 1'b0, exp: 0});
    vecs.push_back('{din: -16'sd32768, chk: 1'b0, exp: 0});
    vecs.push_back('{din: -16'sd32768, chk: 1'b0, exp: 0});
    vecs.push_back('{din: 16'sd32767, chk: 1'b0, exp: 0});
    vecs.push_back('{din: -16'sd32768, chk: 1'b0, exp: 0});
    vecs.push_back('{din: -16'sd32768, chk: 1'b0, exp: 0});
    vecs.push_back('{din: 16'sd32767, chk: 1'b1, exp: 32767});

    foreach (vecs[i]) begin
      send_word(vecs[i].din, 1'b1, vecs[i].chk, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset at the edge of MAC cycle 3: no output, and a clean line afterwards.
    @(negedge mclk1);
    bus.din      = 16'sd0;
    bus.word_clk = 1'b1;
    @(negedge mclk1);
    bus.word_clk = 1'b0;
    @(negedge mclk1);
    @(negedge mclk1);
    reset_n = 1'b0;
    @(negedge mclk1);
    reset_n = 1'b1;
    check("midmac_dout", longint'(bus.dout), 0);
    check("midmac_overrun", longint'(bus.overrun), 0);
    p0 = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge mclk1);
      if (bus.dout_valid) p0++;
    end
    check("midmac_no_valid", p0, 0);
    send_word(16'sd64, 1'b1, 1'b1, 1, "midmac_after");

    // Enable low: word neither shifts nor flags overrun.
    bus.en = 1'b0;
    send_word(16'sd6400, 1'b0, 1'b0, 0, "en_off");
    check("en_off_overrun", longint'(bus.overrun), 0);
    bus.en = 1'b1;
    send_word(16'sd0, 1'b1, 1'b1, -4, "en_resume");

    // Words every 4 clocks: 2nd lands in MAC, 3rd on the SAT edge, both dropped.
    reset_dut();
    ov_vals = '{16'sd64, 16'sd6400, 16'sd6400, 16'sd0};
    got.delete();
    for (int i = 0; i < 32; i++) begin
      @(negedge mclk1);
      if (bus.dout_valid) got.push_back(int'(bus.dout));
      if (i == 4) check("ovr_before_2nd", longint'(bus.overrun), 0);
      if (i == 6) check("ovr_after_2nd", longint'(bus.overrun), 1);
      bus.word_clk = (i < 16) && (i % 4 == 0);
      if (i < 16) bus.din = ov_vals[i/4];
    end
    bus.word_clk = 1'b0;
    check("ovr_sticky", longint'(bus.overrun), 1);
    check("ovr_out_count", got.size(), 2);
    check("ovr_out0", (got.size() > 0) ? got[0] : 99999, 1);
    check("ovr_out1", (got.size() > 1) ? got[1] : 99999, -4);

    // Decimate by 2: all 8 words shift, only odd-numbered words produce output.
    reset_dut();
    bus.dec2 = 1'b1;
    d2_vals = '{16'sd0, 16'sd64, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd64};
    d2_exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    d2_val  = '{0, 0, -4, 0, 94, 0, -4, 0};
    p0 = n_pulses;
    for (int i = 0; i < 8; i++) begin
      send_word(d2_vals[i], d2_exp[i], 1'b1, d2_val[i], $sformatf("dec2_w%0d", i + 1));
    end
    check("dec2_pulses", n_pulses - p0, 4);
    bus.dec2 = 1'b0;
    send_word(16'sd0, 1'b1, 1'b1, -4, "dec2_w9");
    send_word(16'sd0, 1'b1, 1'b1, -12, "dec2_w10");
    check("dec2_no_overrun", longint'(bus.overrun), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
